// File: rtl/u_xmit_pkg.sv
// Shared types for the configurable UART transmitter: FSM states and parity mode codes.
package u_xmit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } xmit_state_e;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10,
    PAR_RSVD = 2'b11
  } par_mode_e;

  // Reserved code behaves like no parity.
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/u_bitcell_cntr.sv
// Bit-cell timer: counts sys_clk cycles within one bit cell and flags the last cycle.
module u_bitcell_cntr
  import u_xmit_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic cell_end
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OVERSAMPLE - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign cell_end = enable && (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cell_end ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/u_xmit_cfg.sv
// UART transmitter with per-frame parity and stop-bit configuration latched at acceptance.
module u_xmit_cfg
  import u_xmit_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              xmit_validH,
  output logic              xmit_readyH,
  input  logic [DATA_W-1:0] xmit_dataH,
  input  logic [1:0]        parity_modeH,
  input  logic              stop2H,
  output logic              uart_xmitH,
  output logic              xmit_busyH,
  output logic              xmit_doneH
);

  localparam int unsigned IDX_W = $clog2(DATA_W + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  xmit_state_e       state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              pen_q, pen_d;
  logic              par_q, par_d;
  logic              st2_q, st2_d;
  logic              stop_sec_q, stop_sec_d;
  logic              line_q, line_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cell_end;

  u_bitcell_cntr #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_cntr (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .enable  (state_q != ST_IDLE),
    .clear   (state_q == ST_IDLE),
    .cell_end(cell_end)
  );

  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    idx_d      = idx_q;
    pen_d      = pen_q;
    par_d      = par_q;
    st2_d      = st2_q;
    stop_sec_d = stop_sec_q;
    line_d     = line_q;
    ready_d    = ready_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        line_d  = 1'b1;
        ready_d = 1'b1;
        if (xmit_validH && ready_q) begin
          state_d    = ST_START;
          line_d     = 1'b0;
          ready_d    = 1'b0;
          busy_d     = 1'b1;
          sh_d       = xmit_dataH;
          pen_d      = parity_enabled(parity_modeH);
          par_d      = (^xmit_dataH) ^ (parity_modeH == PAR_ODD);
          st2_d      = stop2H;
          idx_d      = '0;
          stop_sec_d = 1'b0;
        end
      end
      ST_START: begin
        if (cell_end) begin
          state_d = ST_DATA;
          line_d  = sh_q[0];
          sh_d    = sh_q >> 1;
        end
      end
      ST_DATA: begin
        if (cell_end) begin
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) begin
            state_d = pen_q ? ST_PARITY : ST_STOP;
            line_d  = pen_q ? par_q : 1'b1;
          end else begin
            line_d = sh_q[0];
            sh_d   = sh_q >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (cell_end) begin
          state_d = ST_STOP;
          line_d  = 1'b1;
        end
      end
      ST_STOP: begin
        if (cell_end) begin
          // Second stop cell only when requested; otherwise frame completes here.
          if (st2_q && !stop_sec_q) begin
            stop_sec_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            ready_d = 1'b1;
            busy_d  = 1'b0;
            line_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        line_d  = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= ST_IDLE;
      sh_q       <= '0;
      idx_q      <= '0;
      pen_q      <= 1'b0;
      par_q      <= 1'b0;
      st2_q      <= 1'b0;
      stop_sec_q <= 1'b0;
      line_q     <= 1'b1;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      idx_q      <= idx_d;
      pen_q      <= pen_d;
      par_q      <= par_d;
      st2_q      <= st2_d;
      stop_sec_q <= stop_sec_d;
      line_q     <= line_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign uart_xmitH  = line_q;
  assign xmit_readyH = ready_q;
  assign xmit_busyH  = busy_q;
  assign xmit_doneH  = done_q;

endmodule

// File: tb/tb_u_xmit_cfg.sv
// Bench for u_xmit_cfg: three instances (8/16, 5/2, 9/2) checked against a frame-level line model.
module tb_u_xmit_cfg;

  logic       clk;
  logic       rst;
  logic [2:0] valid;
  logic [8:0] din;
  logic [1:0] mode;
  logic       stop2;
  logic [2:0] line_w, ready_w, busy_w, done_w;

  int n_cmp = 0;
  int n_bad = 0;

  u_xmit_cfg #(.DATA_W(8), .OVERSAMPLE(16)) dut0 (
    .sys_clk(clk), .sys_rst(rst), .xmit_validH(valid[0]), .xmit_readyH(ready_w[0]),
    .xmit_dataH(din[7:0]), .parity_modeH(mode), .stop2H(stop2),
    .uart_xmitH(line_w[0]), .xmit_busyH(busy_w[0]), .xmit_doneH(done_w[0]));

  u_xmit_cfg #(.DATA_W(5), .OVERSAMPLE(2)) dut1 (
    .sys_clk(clk), .sys_rst(rst), .xmit_validH(valid[1]), .xmit_readyH(ready_w[1]),
    .xmit_dataH(din[4:0]), .parity_modeH(mode), .stop2H(stop2),
    .uart_xmitH(line_w[1]), .xmit_busyH(busy_w[1]), .xmit_doneH(done_w[1]));

  u_xmit_cfg #(.DATA_W(9), .OVERSAMPLE(2)) dut2 (
    .sys_clk(clk), .sys_rst(rst), .xmit_validH(valid[2]), .xmit_readyH(ready_w[2]),
    .xmit_dataH(din), .parity_modeH(mode), .stop2H(stop2),
    .uart_xmitH(line_w[2]), .xmit_busyH(busy_w[2]), .xmit_doneH(done_w[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Sends one frame on instance sel and checks every cycle of it against the expected bit list.
  task automatic send_frame(input int sel, input logic [8:0] data, input logic [1:0] md,
                            input logic st2, input bit keep_valid);
    int dw, os, total;
    bit p;
    bit bits[$];
    dw = (sel == 0) ? 8 : (sel == 1) ? 5 : 9;
    os = (sel == 0) ? 16 : 2;
    p  = 1'b0;
    bits.push_back(1'b0);
    for (int i = 0; i < dw; i++) begin
      bits.push_back(data[i]);
      p ^= data[i];
    end
    if (md == 2'b01) bits.push_back(p);
    if (md == 2'b10) bits.push_back(~p);
    bits.push_back(1'b1);
    if (st2) bits.push_back(1'b1);
    total = bits.size() * os;

    @(negedge clk);
    check_val("ready_before", 32'(ready_w[sel]), 32'd1);
    valid[sel] = 1'b1;
    din   = data;
    mode  = md;
    stop2 = st2;
    @(posedge clk); #1;
    if (!keep_valid) valid[sel] = 1'b0;
    for (int c = 0; c < total; c++) begin
      check_val($sformatf("line%0d_c%0d", sel, c), 32'(line_w[sel]), 32'(bits[c / os]));
      check_val($sformatf("done%0d_c%0d", sel, c), 32'(done_w[sel]), 32'd0);
      check_val($sformatf("busy%0d_c%0d", sel, c), 32'(busy_w[sel]), 32'd1);
      check_val($sformatf("ready%0d_c%0d", sel, c), 32'(ready_w[sel]), 32'd0);
      din   = 9'($urandom);
      mode  = 2'($urandom);
      stop2 = 1'($urandom);
      @(posedge clk); #1;
    end
    check_val($sformatf("done%0d_end", sel), 32'(done_w[sel]), 32'd1);
    check_val($sformatf("ready%0d_end", sel), 32'(ready_w[sel]), 32'd1);
    check_val($sformatf("busy%0d_end", sel), 32'(busy_w[sel]), 32'd0);
    check_val($sformatf("line%0d_end", sel), 32'(line_w[sel]), 32'd1);
  endtask

  initial begin
    rst   = 1'b1;
    valid = '0;
    din   = '0;
    mode  = '0;
    stop2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_line", 32'(line_w), 32'h7);
    check_val("rst_ready", 32'(ready_w), 32'h7);
    check_val("rst_busy", 32'(busy_w), 32'h0);
    check_val("rst_done", 32'(done_w), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    send_frame(0, 9'h055, 2'b00, 1'b0, 1'b0);
    send_frame(0, 9'h007, 2'b01, 1'b0, 1'b0);
    send_frame(0, 9'h000, 2'b10, 1'b0, 1'b0);
    send_frame(0, 9'h0FF, 2'b00, 1'b1, 1'b0);
    send_frame(0, 9'h0C3, 2'b11, 1'b0, 1'b0);

    // Valid held across three frames with changing data.
    send_frame(0, 9'($urandom), 2'b01, 1'b0, 1'b1);
    send_frame(0, 9'($urandom), 2'b10, 1'b1, 1'b1);
    send_frame(0, 9'($urandom), 2'b00, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_val("done_one_cycle", 32'(done_w[0]), 32'd0);
    check_val("idle_no_restart", 32'(busy_w[0]), 32'd0);

    // Reset at cycle 50 of a frame whose line is low at that point.
    @(negedge clk);
    valid[0] = 1'b1;
    din = 9'h000;
    mode = 2'b00;
    stop2 = 1'b0;
    @(posedge clk); #1;
    valid[0] = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    check_val("pre_rst_line", 32'(line_w[0]), 32'd0);
    rst = 1'b1;
    #1;
    check_val("mid_rst_line", 32'(line_w[0]), 32'd1);
    check_val("mid_rst_ready", 32'(ready_w[0]), 32'd1);
    check_val("mid_rst_busy", 32'(busy_w[0]), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_val("mid_rst_done", 32'(done_w[0]), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    send_frame(0, 9'h0A5, 2'b01, 1'b1, 1'b0);

    // Randomized frames on every instance.
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 8; i++) begin
        send_frame(s, 9'($urandom), 2'($urandom), 1'($urandom),
                   (i < 7) ? 1'($urandom) : 1'b0);
      end
      valid = '0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
